// File: rtl/ibex_instr_ahbl_bridge.sv
// ibex_instr_ahbl_bridge: Ibex instruction-fetch (req/gnt/rvalid) to single-beat AHB-Lite read master.
// Address and data phases overlap, so zero-wait fetches sustain one word per cycle.
module ibex_instr_ahbl_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    output logic [ADDR_WIDTH-1:0] ahbl_haddr,
    output logic [1:0]            ahbl_htrans,
    output logic [2:0]            ahbl_hburst,
    output logic [2:0]            ahbl_hsize,
    output logic [3:0]            ahbl_hprot,
    output logic                  ahbl_hmastlock,
    output logic                  ahbl_hwrite,
    output logic [DATA_WIDTH-1:0] ahbl_hwdata,
    input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
    input  logic                  ahbl_hready,
    input  logic                  ahbl_hresp
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_e;
    state_e state_q, state_d;
    logic   nonseq;
    logic   data_done;
    logic   err_done;
    // No new address phase while an ERROR response is in progress.
    assign nonseq    = instr_req_i && state_q != S_ERR && !(state_q == S_DATA && ahbl_hresp);
    assign data_done = state_q == S_DATA && ahbl_hready;
    assign err_done  = state_q == S_ERR && ahbl_hready;
    assign instr_gnt_o    = nonseq && ahbl_hready;
    assign instr_rvalid_o = data_done || err_done;
    assign instr_err_o    = err_done || (data_done && ahbl_hresp);
    assign instr_rdata_o  = (data_done && !ahbl_hresp) ? ahbl_hrdata : '0;
    assign ahbl_haddr     = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign ahbl_htrans    = nonseq ? 2'b10 : 2'b00;
    assign ahbl_hburst    = 3'b000;
    assign ahbl_hsize     = 3'b010;
    assign ahbl_hprot     = 4'b0010;
    assign ahbl_hmastlock = 1'b0;
    assign ahbl_hwrite    = 1'b0;
    assign ahbl_hwdata    = '0;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = instr_gnt_o ? S_DATA : S_IDLE;
            S_DATA:  state_d = (ahbl_hresp && !ahbl_hready) ? S_ERR :
                               ahbl_hready ? (instr_gnt_o ? S_DATA : S_IDLE) : S_DATA;
            S_ERR:   state_d = ahbl_hready ? S_IDLE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
endmodule

// File: tb/tb_ibex_instr_ahbl_bridge.sv
// tb_ibex_instr_ahbl_bridge: directed self-checking bench for the Ibex-to-AHB-Lite fetch bridge.
module tb_ibex_instr_ahbl_bridge;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot;
    logic        hmastlock, hwrite;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [4:0]  ctl;

    assign ctl = {gnt, rvalid, err, htrans};

    always #5 clk = ~clk;

    ibex_instr_ahbl_bridge dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
        .ahbl_haddr(haddr), .ahbl_htrans(htrans), .ahbl_hburst(hburst), .ahbl_hsize(hsize),
        .ahbl_hprot(hprot), .ahbl_hmastlock(hmastlock), .ahbl_hwrite(hwrite),
        .ahbl_hwdata(hwdata), .ahbl_hrdata(hrdata), .ahbl_hready(hready), .ahbl_hresp(hresp)
    );

    // ctl = {gnt, rvalid, err, htrans}
    task automatic drive(input logic r, input logic [31:0] a, input logic rdy, input logic rsp,
                         input logic [31:0] d);
        @(negedge clk);
        req = r; addr = a; hready = rdy; hresp = rsp; hrdata = d;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (ctl !== 5'b00000 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got ctl=%b rdata=%h want ctl=00000 rdata=0", ctl, rdata);
        end
        n_checks++;
        if ({hburst, hsize, hprot, hmastlock, hwrite} !== {3'b000, 3'b010, 4'b0010, 1'b0, 1'b0}
            || hwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL const_outputs got burst=%b size=%b prot=%b lock=%b write=%b wdata=%h",
                     hburst, hsize, hprot, hmastlock, hwrite, hwdata);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single();
        drive(1, 32'h106, 1, 0, 32'h0);
        n_checks++;
        if (ctl !== 5'b10010 || haddr !== 32'h104) begin
            n_fail++;
            $display("FAIL single_addr got ctl=%b haddr=%h want ctl=10010 haddr=104", ctl, haddr);
        end
        drive(0, 32'h0, 1, 0, 32'hDEADBEEF);
        n_checks++;
        if (ctl !== 5'b01000 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_data got ctl=%b rdata=%h want ctl=01000 rdata=deadbeef", ctl, rdata);
        end
        drive(0, 32'h0, 1, 0, 32'h12345678);
        n_checks++;
        if (ctl !== 5'b00000 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL single_after got ctl=%b rdata=%h want ctl=00000 rdata=0", ctl, rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            logic [4:0]  exp_ctl;
            logic [31:0] exp_d;
            exp_ctl = {i < 4, i > 0, 1'b0, (i < 4) ? 2'b10 : 2'b00};
            exp_d   = (i > 0) ? 32'hA0000000 + 32'(i - 1) : 32'h0;
            drive(i < 4, 32'(i * 4), 1, 0, 32'hA0000000 + 32'(i - 1));
            n_checks++;
            if (ctl !== exp_ctl || rdata !== exp_d || (i < 4 && haddr !== 32'(i * 4))) begin
                n_fail++;
                $display("FAIL b2b_%0d got ctl=%b rdata=%h haddr=%h want ctl=%b rdata=%h haddr=%h",
                         i, ctl, rdata, haddr, exp_ctl, exp_d, i * 4);
            end
        end
    endtask

    task automatic test_wait_states();
        drive(1, 32'h10, 1, 0, 32'h0);
        n_checks++;
        if (ctl !== 5'b10010 || haddr !== 32'h10) begin
            n_fail++;
            $display("FAIL wait_gnt0 got ctl=%b haddr=%h want ctl=10010 haddr=10", ctl, haddr);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h14, 0, 0, 32'hFFFFFFFF);
            n_checks++;
            if (ctl !== 5'b00010 || haddr !== 32'h14 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL wait_hold_%0d got ctl=%b haddr=%h rdata=%h want ctl=00010 haddr=14 rdata=0",
                         i, ctl, haddr, rdata);
            end
        end
        drive(1, 32'h14, 1, 0, 32'h11111111);
        n_checks++;
        if (ctl !== 5'b11010 || rdata !== 32'h11111111) begin
            n_fail++;
            $display("FAIL wait_release got ctl=%b rdata=%h want ctl=11010 rdata=11111111", ctl, rdata);
        end
        drive(0, 32'h0, 1, 0, 32'h22222222);
        n_checks++;
        if (ctl !== 5'b01000 || rdata !== 32'h22222222) begin
            n_fail++;
            $display("FAIL wait_second got ctl=%b rdata=%h want ctl=01000 rdata=22222222", ctl, rdata);
        end
    endtask

    task automatic test_error();
        drive(1, 32'h20, 1, 0, 32'h0);
        n_checks++;
        if (ctl !== 5'b10010 || haddr !== 32'h20) begin
            n_fail++;
            $display("FAIL err_gnt got ctl=%b haddr=%h want ctl=10010 haddr=20", ctl, haddr);
        end
        drive(1, 32'h24, 0, 1, 32'h0BAD0BAD);
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL err_first got ctl=%b want 00000", ctl);
        end
        drive(1, 32'h24, 1, 1, 32'h0BAD0BAD);
        n_checks++;
        if (ctl !== 5'b01100 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL err_second got ctl=%b rdata=%h want ctl=01100 rdata=0", ctl, rdata);
        end
        drive(1, 32'h24, 1, 0, 32'h0);
        n_checks++;
        if (ctl !== 5'b10010 || haddr !== 32'h24) begin
            n_fail++;
            $display("FAIL err_next_gnt got ctl=%b haddr=%h want ctl=10010 haddr=24", ctl, haddr);
        end
        drive(0, 32'h0, 1, 0, 32'h24242424);
        n_checks++;
        if (ctl !== 5'b01000 || rdata !== 32'h24242424) begin
            n_fail++;
            $display("FAIL err_next_data got ctl=%b rdata=%h want ctl=01000 rdata=24242424", ctl, rdata);
        end
    endtask

    task automatic test_error_one_cycle();
        drive(1, 32'h30, 1, 0, 32'h0);
        drive(1, 32'h34, 1, 1, 32'h5A5A5A5A);
        n_checks++;
        if (ctl !== 5'b01100 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL err1_complete got ctl=%b rdata=%h want ctl=01100 rdata=0", ctl, rdata);
        end
        drive(0, 32'h0, 1, 0, 32'h0);
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL err1_idle got ctl=%b want 00000", ctl);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h40, 1, 0, 32'h0);
        @(negedge clk);
        req = 1'b0; rstn = 1'b0; hrdata = 32'h77777777;
        #1;
        n_checks++;
        if (ctl !== 5'b00000 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid got ctl=%b rdata=%h want ctl=00000 rdata=0", ctl, rdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_after got ctl=%b want 00000", ctl);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            drive(0, 32'h100 + 32'(i * 4), 1, 0, 32'hCAFE0000 + 32'(i));
            n_checks++;
            if (ctl !== 5'b00000 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_%0d got ctl=%b rdata=%h want ctl=00000 rdata=0", i, ctl, rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_error_one_cycle();
        test_reset_mid();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
